// File: rtl/dmem_ctrl.sv
// Data-memory controller: one-outstanding request/response port in front of
// a word-organised RAM and a small special-register space (IDs, switches,
// LED register, free-running cycle counter).
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1,
  parameter int N_SW        = 16,
  parameter int N_LED       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_se,
  input  logic [1:0]       req_bs,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_LED-1:0] led_out
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       led_q, led_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [N_SW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              xfer;
  logic              acc_err, is_ram, is_led, read_only;
  logic [19:0]       ram_hi;
  logic [IDX_W-1:0]  ram_idx;
  logic [31:0]       rd_word, load_data, wdata_al;
  logic [3:0]        be;
  logic              ram_we, led_we;

  // Select the addressed lane(s), right-align, and extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] bs,
                                           input logic [1:0] off, input logic se);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (bs)
      2'b01:   load_ext = se ? 32'(b) : {24'h0, sh[7:0]};
      2'b10:   load_ext = se ? 32'(h) : {16'h0, sh[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  assign xfer = req_valid && (state_q == IDLE);

  // Address decode, access-fault detection and read-word selection.
  always_comb begin
    acc_err   = 1'b0;
    is_ram    = 1'b0;
    is_led    = 1'b0;
    read_only = 1'b0;
    rd_word   = 32'h0;
    ram_hi    = req_addr[19:0] >> (IDX_W + 2);
    ram_idx   = req_addr[IDX_W+1:2];
    case (req_addr[31:20])
      12'h800: begin
        if (ram_hi != 20'h0) acc_err = 1'b1;
        else begin
          is_ram  = 1'b1;
          rd_word = mem[ram_idx];
        end
      end
      12'h001: begin
        if (req_addr[19:5] != 15'h0) acc_err = 1'b1;
        else begin
          case (req_addr[4:2])
            3'd0: begin rd_word = 32'h00D9AC08; read_only = 1'b1; end
            3'd1: begin rd_word = 32'h00A9E27E; read_only = 1'b1; end
            3'd2: begin rd_word = 32'h00BECA97; read_only = 1'b1; end
            3'd4: begin rd_word = 32'(sync2_q); read_only = 1'b1; end
            3'd5: begin rd_word = led_q;        is_led    = 1'b1; end
            3'd6: begin rd_word = cyc_q;        read_only = 1'b1; end
            default: acc_err = 1'b1;
          endcase
        end
      end
      default: acc_err = 1'b1;
    endcase
    if (req_bs == 2'b00)                            acc_err = 1'b1;
    if (req_bs == 2'b10 && req_addr[0])             acc_err = 1'b1;
    if (req_bs == 2'b11 && req_addr[1:0] != 2'b00)  acc_err = 1'b1;
    if (req_we && read_only)                        acc_err = 1'b1;
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    case (req_bs)
      2'b01: begin
        be       = 4'b0001 << req_addr[1:0];
        wdata_al = {4{req_wdata[7:0]}};
      end
      2'b10: begin
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{req_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_al = req_wdata;
      end
    endcase
    load_data = load_ext(rd_word, req_bs, req_addr[1:0], req_se);
    ram_we    = xfer && req_we && !acc_err && is_ram;
    led_we    = xfer && req_we && !acc_err && is_led;
  end

  // Next-state logic for the IDLE -> ACCESS -> RESP handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = ACCESS;
      ACCESS:  if (lat_q == 2'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded handshake outputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Latency counter, response capture, LED merge, counter and synchroniser.
  always_comb begin
    lat_d   = lat_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
    if (xfer) begin
      lat_d   = 2'(RD_LAT - 1);
      rdata_d = (acc_err || req_we) ? 32'h0 : load_data;
      err_d   = acc_err;
    end else if (state_q == ACCESS && lat_q != 2'd0) begin
      lat_d = lat_q - 2'd1;
    end
    if (led_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) led_d[8*i +: 8] = wdata_al[8*i +: 8];
    end
    cyc_d   = cyc_q + 32'd1;
    sync1_d = sw_in;
    sync2_d = sync1_q;
  end

  // Control and register state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      led_q   <= 32'h0;
      cyc_q   <= 32'h0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
      cyc_q   <= cyc_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // RAM byte-lane write at the transfer edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[ram_idx][8*i +: 8] <= wdata_al[8*i +: 8];
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign led_out   = led_q[N_LED-1:0];

endmodule
